vcore_vcfg_ctrl: RTL

// - Per-thread vector-configuration controller for the Vcore front end. Executes vsetvl-style requests:

---
 rtl/vcore_vcfg_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/vcore_vcfg_ctrl.sv
// vcore_vcfg_ctrl: per-thread vector configuration controller.
// Executes vsetvl-style requests (SEW decode, VL = min(AVL or current VL, VLMAX)),
// commits per-thread VL/SEW/VILL CSRs and tracks outstanding vector instructions
// per thread so that a vsetvl is only accepted once its thread has drained.
// Optional build macro: VCORE_VCFG_PMU_EN adds pmu_vset_cnt_o / pmu_stall_cnt_o.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   req_*  (vld/rdy/tid/avl/sew/keep) vsetvl request channel from issue
//   rsp_*  (vld/rdy/tid/vl/err)       committed-configuration response
//   iss_*  (vld/tid/rdy), ret_*       vector instruction issue / retire strobes
//   csr_vl_o/csr_sew_o/csr_vill_o     flat per-thread CSR read ports, thread 0 in LSBs
//   ots_zero_o                        per-thread outstanding counter == 0
module vcore_vcfg_ctrl #(
  parameter int unsigned THREAD_CNT = 4,
  parameter int unsigned VDP_W      = 512,
  parameter int unsigned VLEN_W     = 7,
  parameter int unsigned AVL_W      = 16,
  parameter int unsigned OTS_CTR_W  = 5,
`ifdef VCORE_VCFG_PMU_EN
  parameter int unsigned PMU_EVT_W  = 64,
`endif
  localparam int unsigned TID_W     = (THREAD_CNT > 1) ? $clog2(THREAD_CNT) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_vld_i,
  output logic                         req_rdy_o,
  input  logic [TID_W-1:0]             req_tid_i,
  input  logic [AVL_W-1:0]             req_avl_i,
  input  logic [1:0]                   req_sew_i,
  input  logic                         req_keep_i,
  output logic                         rsp_vld_o,
  input  logic                         rsp_rdy_i,
  output logic [TID_W-1:0]             rsp_tid_o,
  output logic [VLEN_W-1:0]            rsp_vl_o,
  output logic                         rsp_err_o,
  input  logic                         iss_vld_i,
  input  logic [TID_W-1:0]             iss_tid_i,
  output logic                         iss_rdy_o,
  input  logic                         ret_vld_i,
  input  logic [TID_W-1:0]             ret_tid_i,
  output logic [THREAD_CNT*VLEN_W-1:0] csr_vl_o,
  output logic [THREAD_CNT*2-1:0]      csr_sew_o,
  output logic [THREAD_CNT-1:0]        csr_vill_o,
  output logic [THREAD_CNT-1:0]        ots_zero_o
`ifdef VCORE_VCFG_PMU_EN
  ,
  output logic [PMU_EVT_W-1:0]         pmu_vset_cnt_o,
  output logic [PMU_EVT_W-1:0]         pmu_stall_cnt_o
`endif
);

  localparam int unsigned CMP_W = (AVL_W > VLEN_W) ? AVL_W : VLEN_W;
  localparam logic [OTS_CTR_W-1:0] OTS_MAX = '1;
  localparam logic [VLEN_W-1:0] VLMAX_8  = VLEN_W'(VDP_W / 8);
  localparam logic [VLEN_W-1:0] VLMAX_16 = VLEN_W'(VDP_W / 16);
  localparam logic [VLEN_W-1:0] VLMAX_32 = VLEN_W'(VDP_W / 32);

  // S1 stage
  logic              s1_vld_q;
  logic [TID_W-1:0]  s1_tid_q;
  logic [AVL_W-1:0]  s1_avl_q;
  logic [1:0]        s1_sew_q;
  logic              s1_keep_q;
  logic [VLEN_W-1:0] s1_vlmax_q;
  // S2 stage (response)
  logic              rsp_vld_q;
  logic [TID_W-1:0]  rsp_tid_q;
  logic [VLEN_W-1:0] rsp_vl_q;
  logic              rsp_err_q;
  // CSRs and counters
  logic [THREAD_CNT-1:0][VLEN_W-1:0]    csr_vl_q;
  logic [THREAD_CNT-1:0][1:0]           csr_sew_q;
  logic [THREAD_CNT-1:0]                csr_vill_q;
  logic [THREAD_CNT-1:0][OTS_CTR_W-1:0] ots_q, ots_d;

  logic              s1_adv;
  logic              req_acc;
  logic [VLEN_W-1:0] vlmax_d;
  logic [VLEN_W-1:0] cur_vl;
  logic [CMP_W-1:0]  vl_src;
  logic [VLEN_W-1:0] vl_d;
  logic              err_d;
  logic              commit;

  // Request handshake and VLMAX decode at accept
  always_comb begin
    s1_adv  = !rsp_vld_q || rsp_rdy_i;
    for (int t = 0; t < THREAD_CNT; t++) ots_zero_o[t] = (ots_q[t] == '0);
    req_rdy_o = (!s1_vld_q || s1_adv) && ots_zero_o[req_tid_i] &&
                !(s1_vld_q && (s1_tid_q == req_tid_i));
    req_acc = req_vld_i && req_rdy_o;
    iss_rdy_o = (ots_q[iss_tid_i] != OTS_MAX);
    unique case (req_sew_i)
      2'b00:   vlmax_d = VLMAX_8;
      2'b01:   vlmax_d = VLMAX_16;
      2'b10:   vlmax_d = VLMAX_32;
      default: vlmax_d = '0;
    endcase
  end

  // VL resolve in S1. The CSR write happens on the S1->S2 edge and the
  // same-thread guard on req_rdy keeps a second request for a thread out of S1
  // until its predecessor has committed, so the CSR already carries the
  // freshest committed VL for keep-mode requests.
  always_comb begin
    cur_vl = csr_vl_q[s1_tid_q];
    vl_src = s1_keep_q ? CMP_W'(cur_vl) : CMP_W'(s1_avl_q);
    err_d  = (s1_sew_q == 2'b11);
    if (err_d)                           vl_d = '0;
    else if (vl_src < CMP_W'(s1_vlmax_q)) vl_d = VLEN_W'(vl_src);
    else                                 vl_d = s1_vlmax_q;
    commit = s1_vld_q && s1_adv;
  end

  // Outstanding counters; a simultaneous issue and retire on one thread cancel
  always_comb begin
    ots_d = ots_q;
    for (int t = 0; t < THREAD_CNT; t++) begin
      if ((iss_vld_i && iss_rdy_o && (iss_tid_i == TID_W'(t))) &&
          !(ret_vld_i && (ret_tid_i == TID_W'(t)) && (ots_q[t] != '0)))
        ots_d[t] = ots_q[t] + OTS_CTR_W'(1);
      else if (!(iss_vld_i && iss_rdy_o && (iss_tid_i == TID_W'(t))) &&
               (ret_vld_i && (ret_tid_i == TID_W'(t)) && (ots_q[t] != '0)))
        ots_d[t] = ots_q[t] - OTS_CTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_tid_q   <= '0;
      s1_avl_q   <= '0;
      s1_sew_q   <= '0;
      s1_keep_q  <= 1'b0;
      s1_vlmax_q <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_tid_q  <= '0;
      rsp_vl_q   <= '0;
      rsp_err_q  <= 1'b0;
      csr_vl_q   <= '0;
      csr_sew_q  <= {THREAD_CNT{2'b01}};
      csr_vill_q <= '1;
      ots_q      <= '0;
    end else begin
      if (req_acc) begin
        s1_vld_q   <= 1'b1;
        s1_tid_q   <= req_tid_i;
        s1_avl_q   <= req_avl_i;
        s1_sew_q   <= req_sew_i;
        s1_keep_q  <= req_keep_i;
        s1_vlmax_q <= vlmax_d;
      end else if (s1_adv) begin
        s1_vld_q <= 1'b0;
      end
      if (s1_adv) begin
        rsp_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          rsp_tid_q <= s1_tid_q;
          rsp_vl_q  <= vl_d;
          rsp_err_q <= err_d;
        end
      end
      // Illegal SEW keeps the previous SEW code
      if (commit) begin
        csr_vl_q[s1_tid_q]   <= vl_d;
        csr_vill_q[s1_tid_q] <= err_d;
        if (!err_d) csr_sew_q[s1_tid_q] <= s1_sew_q;
      end
      ots_q <= ots_d;
    end
  end

  assign rsp_vld_o  = rsp_vld_q;
  assign rsp_tid_o  = rsp_tid_q;
  assign rsp_vl_o   = rsp_vl_q;
  assign rsp_err_o  = rsp_err_q;
  assign csr_vl_o   = csr_vl_q;
  assign csr_sew_o  = csr_sew_q;
  assign csr_vill_o = csr_vill_q;

`ifdef VCORE_VCFG_PMU_EN
  logic [PMU_EVT_W-1:0] pmu_vset_q;
  logic [PMU_EVT_W-1:0] pmu_stall_q;

  // Event counters, free-running with natural wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pmu_vset_q  <= '0;
      pmu_stall_q <= '0;
    end else begin
      if (req_acc)                 pmu_vset_q  <= pmu_vset_q + PMU_EVT_W'(1);
      if (req_vld_i && !req_rdy_o) pmu_stall_q <= pmu_stall_q + PMU_EVT_W'(1);
    end
  end

  assign pmu_vset_cnt_o  = pmu_vset_q;
  assign pmu_stall_cnt_o = pmu_stall_q;
`endif

  // Retiring on a thread with nothing outstanding indicates an issue-stage bug
  a_ret_on_zero: assert property (@(posedge clk) disable iff (rst)
    ret_vld_i |-> (ots_q[ret_tid_i] != '0));

endmodule
